rsp_router_2x1: RTL and testbench

RSP_ROUTER_2X1 -- requirements
Module: rsp_router_2x1

---
 rtl/arb_pkg.sv | 23 ++
 rtl/rsp_order_fifo.sv | 55 +++++
 rtl/rsp_router_2x1.sv | 98 +++++++++
 tb/tb_rsp_router_2x1.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants for the 2-requester arbiter / response router slice:
// size defaults, grant encodings and the output-stage state type.
package arb_pkg;

  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 4;
  localparam int ID_W      = 1;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_R0   = 2'b01;
  localparam logic [1:0] GNT_R1   = 2'b10;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } stage_e;

  // Requester ID carried by a one-hot grant (bit 1 set means requester 1).
  function automatic logic [ID_W-1:0] gnt_to_id(input logic [1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/rsp_order_fifo.sv
// Order FIFO of requester IDs. A push on a full FIFO is taken only when a
// pop happens in the same cycle; a pop on an empty FIFO is ignored.
module rsp_order_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     push_id,
  input  logic                     pop,
  output logic                     head_id,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head_id = mem[rd_ptr];

  // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/rsp_router_2x1.sv
// Routes responses from one shared target back to the granted requester in
// grant order, through a one-entry EMPTY/HOLD output stage.
module rsp_router_2x1
  import arb_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             grant,
  input  logic                   tgt_rsp_valid,
  input  logic [DW-1:0]          tgt_rsp_data,
  output logic                   tgt_rsp_ready,
  output logic [1:0]             rsp_valid,
  output logic [DW-1:0]          rsp_data,
  input  logic [1:0]             rsp_ready,
  output logic [$clog2(DEPTH):0] pend_cnt,
  output logic                   err_orphan,
  output logic                   err_grant
);

  stage_e          state;
  stage_e          state_nxt;
  logic [ID_W-1:0] hold_id;
  logic [DW-1:0]   hold_data;

  logic fifo_full;
  logic fifo_empty;
  logic head_id;
  logic push;
  logic pop;
  logic taken;
  logic accept;
  logic orphan;

  // Inputs are ignored while rst is high so nothing leaks into the cleared state.
  assign push   = !rst && (grant == GNT_R0 || grant == GNT_R1);
  assign taken  = (state == ST_HOLD) && rsp_ready[hold_id];
  assign tgt_rsp_ready = rst || fifo_empty || (state == ST_EMPTY) || taken;
  assign accept = !rst && tgt_rsp_valid && tgt_rsp_ready;
  // The response sees the FIFO as it was before any same-cycle push.
  assign pop    = accept && !fifo_empty;
  assign orphan = accept && fifo_empty;

  rsp_order_fifo #(
    .DEPTH (DEPTH)
  ) u_order_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_id (gnt_to_id(grant)),
    .pop     (pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (pend_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: a default assignment first keeps this combinational block from inferring a latch.
    state_nxt = state;
    if (pop)        state_nxt = ST_HOLD;
    else if (taken) state_nxt = ST_EMPTY;
  end

  always_comb begin
    rsp_valid = 2'b00;
    if (state == ST_HOLD) rsp_valid[hold_id] = 1'b1;
    rsp_data = hold_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_id   <= '0;
      hold_data <= '0;
    end else if (pop) begin
      hold_id   <= head_id;
      hold_data <= tgt_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_orphan <= 1'b0;
      err_grant  <= 1'b0;
    end else begin
      if (orphan) err_orphan <= 1'b1;
      if (grant == 2'b11 || (push && fifo_full && !pop)) err_grant <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rsp_router_2x1.sv
// Directed bench for rsp_router_2x1 (DW=32, DEPTH=4) with hand-computed
// expected values for routing, backpressure, full FIFO, orphans and reset.
module tb_rsp_router_2x1;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic [1:0]    grant;
  logic          tgt_rsp_valid;
  logic [DW-1:0] tgt_rsp_data;
  logic          tgt_rsp_ready;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_ready;
  logic [2:0]    pend_cnt;
  logic          err_orphan;
  logic          err_grant;

  int checks = 0;
  int errors = 0;

  rsp_router_2x1 #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .grant         (grant),
    .tgt_rsp_valid (tgt_rsp_valid),
    .tgt_rsp_data  (tgt_rsp_data),
    .tgt_rsp_ready (tgt_rsp_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_ready     (rsp_ready),
    .pend_cnt      (pend_cnt),
    .err_orphan    (err_orphan),
    .err_grant     (err_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; outputs are then sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [1:0]  exp_v [4];
    logic [31:0] exp_d;

    // Reset, with junk on the inputs that must not raise any flag.
    rst = 1'b1; grant = 2'b11; tgt_rsp_valid = 1'b1;
    tgt_rsp_data = 32'hDEAD_BEEF; rsp_ready = 2'b00;
    settle();
    check("rst_tgt_ready", 64'(tgt_rsp_ready), 64'h1);
    tick(); tick();
    rst = 1'b0; grant = 2'b00; tgt_rsp_valid = 1'b0;
    settle();
    check("rst_pend", 64'(pend_cnt), 64'h0);
    check("rst_valid", 64'(rsp_valid), 64'h0);
    check("rst_data", 64'(rsp_data), 64'h0);
    check("rst_err_orphan", 64'(err_orphan), 64'h0);
    check("rst_err_grant", 64'(err_grant), 64'h0);

    // In-order routing: grants 01,10,10 then responses A,B,C.
    rsp_ready = 2'b11;
    grant = 2'b01; tick();
    grant = 2'b10; tick();
    grant = 2'b10; tick();
    grant = 2'b00;
    settle();
    check("order_pend3", 64'(pend_cnt), 64'h3);
    tgt_rsp_valid = 1'b1; tgt_rsp_data = 32'hAAAA_0001;
    settle();
    check("order_ready_a", 64'(tgt_rsp_ready), 64'h1);
    tick();
    tgt_rsp_data = 32'hBBBB_0002;
    settle();
    check("order_v_a", 64'(rsp_valid), 64'h1);
    check("order_d_a", 64'(rsp_data), 64'hAAAA_0001);
    check("order_ready_b", 64'(tgt_rsp_ready), 64'h1);
    tick();
    tgt_rsp_data = 32'hCCCC_0003;
    settle();
    check("order_v_b", 64'(rsp_valid), 64'h2);
    check("order_d_b", 64'(rsp_data), 64'hBBBB_0002);
    tick();
    tgt_rsp_valid = 1'b0;
    settle();
    check("order_v_c", 64'(rsp_valid), 64'h2);
    check("order_d_c", 64'(rsp_data), 64'hCCCC_0003);
    check("order_pend0", 64'(pend_cnt), 64'h0);
    tick();
    check("order_idle", 64'(rsp_valid), 64'h0);

    // Backpressure on requester 1 while requester 0 is ready.
    rsp_ready = 2'b01;
    grant = 2'b10; tick();
    grant = 2'b10; tick();
    grant = 2'b00;
    tgt_rsp_valid = 1'b1; tgt_rsp_data = 32'hDDDD_0004;
    tick();
    tgt_rsp_data = 32'hFFFF_0005;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("bp_valid", 64'(rsp_valid), 64'h2);
      check("bp_data", 64'(rsp_data), 64'hDDDD_0004);
      check("bp_tgt_ready", 64'(tgt_rsp_ready), 64'h0);
      tick();
    end
    rsp_ready = 2'b11;
    settle();
    check("bp_release_ready", 64'(tgt_rsp_ready), 64'h1);
    tick();
    tgt_rsp_valid = 1'b0;
    settle();
    check("bp_v_second", 64'(rsp_valid), 64'h2);
    check("bp_d_second", 64'(rsp_data), 64'hFFFF_0005);
    check("bp_pend0", 64'(pend_cnt), 64'h0);
    tick();
    check("bp_idle", 64'(rsp_valid), 64'h0);

    // Full FIFO: five grants, the fifth is dropped.
    grant = 2'b01; tick();
    grant = 2'b10; tick();
    grant = 2'b10; tick();
    grant = 2'b01; tick();
    settle();
    check("full_no_err_yet", 64'(err_grant), 64'h0);
    grant = 2'b10; tick();
    grant = 2'b00;
    settle();
    check("full_pend4", 64'(pend_cnt), 64'h4);
    check("full_err_grant", 64'(err_grant), 64'h1);
    exp_v[0] = 2'b01; exp_v[1] = 2'b10; exp_v[2] = 2'b10; exp_v[3] = 2'b01;
    tgt_rsp_valid = 1'b1; tgt_rsp_data = 32'h1000_0000;
    tick();
    for (int k = 1; k < 4; k++) begin
      tgt_rsp_data = 32'h1000_0000 + 32'(k);
      settle();
      exp_d = 32'h1000_0000 + 32'(k - 1);
      check("full_route_v", 64'(rsp_valid), 64'(exp_v[k-1]));
      check("full_route_d", 64'(rsp_data), 64'(exp_d));
      tick();
    end
    tgt_rsp_valid = 1'b0;
    settle();
    check("full_route_v_last", 64'(rsp_valid), 64'(exp_v[3]));
    check("full_route_d_last", 64'(rsp_data), 64'h1000_0003);
    tick();
    check("full_drained", 64'(rsp_valid), 64'h0);
    check("full_pend0", 64'(pend_cnt), 64'h0);
    check("full_no_orphan", 64'(err_orphan), 64'h0);
    check("full_err_sticky", 64'(err_grant), 64'h1);
    rst = 1'b1; tick();
    rst = 1'b0;
    settle();
    check("full_rst_err", 64'(err_grant), 64'h0);

    // Orphan response with nothing outstanding.
    tgt_rsp_valid = 1'b1; tgt_rsp_data = 32'hEEEE_0006;
    settle();
    check("orphan_ready", 64'(tgt_rsp_ready), 64'h1);
    tick();
    tgt_rsp_valid = 1'b0;
    settle();
    check("orphan_no_valid", 64'(rsp_valid), 64'h0);
    check("orphan_flag", 64'(err_orphan), 64'h1);
    tick(); tick();
    check("orphan_sticky", 64'(err_orphan), 64'h1);
    check("orphan_valid_idle", 64'(rsp_valid), 64'h0);

    // Simultaneous push and pop at full: new ID 0 goes behind four ID 1s.
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      grant = 2'b10; tick();
    end
    grant = 2'b00;
    settle();
    check("pp_pend4", 64'(pend_cnt), 64'h4);
    grant = 2'b01; tgt_rsp_valid = 1'b1; tgt_rsp_data = 32'h2000_0000;
    tick();
    grant = 2'b00;
    settle();
    check("pp_pend_kept", 64'(pend_cnt), 64'h4);
    check("pp_no_err", 64'(err_grant), 64'h0);
    for (int k = 1; k < 5; k++) begin
      tgt_rsp_data = 32'h2000_0000 + 32'(k);
      settle();
      exp_d = 32'h2000_0000 + 32'(k - 1);
      check("pp_v", 64'(rsp_valid), 64'h2);
      check("pp_d", 64'(rsp_data), 64'(exp_d));
      tick();
    end
    tgt_rsp_valid = 1'b0;
    settle();
    check("pp_new_id_last", 64'(rsp_valid), 64'h1);
    check("pp_new_id_data", 64'(rsp_data), 64'h2000_0004);
    check("pp_pend0", 64'(pend_cnt), 64'h0);
    tick();
    check("pp_idle", 64'(rsp_valid), 64'h0);

    // Reset mid-stream while holding with three IDs outstanding.
    rsp_ready = 2'b00;
    grant = 2'b01; tick();
    grant = 2'b10; tick();
    grant = 2'b01; tick();
    grant = 2'b10; tick();
    grant = 2'b00;
    tgt_rsp_valid = 1'b1; tgt_rsp_data = 32'h3333_0007;
    tick();
    tgt_rsp_valid = 1'b0;
    grant = 2'b11; tick();
    grant = 2'b00;
    settle();
    check("mid_hold_v", 64'(rsp_valid), 64'h1);
    check("mid_pend3", 64'(pend_cnt), 64'h3);
    check("mid_err_grant", 64'(err_grant), 64'h1);
    rst = 1'b1; tick();
    rst = 1'b0;
    settle();
    check("mid_rst_v", 64'(rsp_valid), 64'h0);
    check("mid_rst_pend", 64'(pend_cnt), 64'h0);
    check("mid_rst_orphan", 64'(err_orphan), 64'h0);
    check("mid_rst_grant", 64'(err_grant), 64'h0);
    check("mid_rst_data", 64'(rsp_data), 64'h0);
    rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_no_rsp", 64'(rsp_valid), 64'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
